// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by fetch and decode.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;
  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [INST_W-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush and occupancy count.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             din,
  input  logic                     pop,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_pop, do_push;
  assign do_pop = pop && count != '0;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (count != CW'(DEPTH) || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(do_pop);
      wr_ptr <= wr_ptr + AW'(do_push);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC owner, imem requester and buffered instruction source for decode.
// Define INST_FETCH_BYPASS_EN to present a response to decode in its arrival cycle.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [31:0] pc;
  logic [CW-1:0] outstanding, drop_cnt, drop_next, out_after, fifo_count, pcq_count;
  logic [CW:0] budget;
  logic rsp_acc, keep, bypass, req_fire, fifo_push, fifo_pop, unused_pcq;
  fetch_entry_t fifo_dout, pcq_dout;
  assign rsp_acc = imem_rsp_valid && outstanding != '0;
  assign keep = rsp_acc && drop_cnt == '0 && !redirect_valid;
`ifdef INST_FETCH_BYPASS_EN
  assign bypass = keep && fifo_count == '0;
`else
  assign bypass = 1'b0;
`endif
  assign inst_valid = fifo_count != '0 || bypass;
  assign inst = fifo_count != '0 ? fifo_dout.inst : bypass ? imem_rsp_data : '0;
  assign inst_pc = fifo_count != '0 ? fifo_dout.pc : bypass ? pcq_dout.pc : '0;
  assign fifo_pop = inst_ready && fifo_count != '0;
  assign fifo_push = keep && !(bypass && inst_ready);
  // counting this cycle's pop lets a 1-cycle memory sustain one word per cycle
  assign budget = {1'b0, fifo_count} - {{CW{1'b0}}, fifo_pop} + {1'b0, outstanding};
  assign imem_req_valid = state != BOOT && !redirect_valid && budget < (CW+1)'(FIFO_DEPTH);
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign out_after = outstanding - CW'(rsp_acc);
  assign drop_next = redirect_valid ? out_after : rsp_acc && drop_cnt != '0 ? drop_cnt - 1'b1 : drop_cnt;
  assign unused_pcq = ^{pcq_dout.inst, pcq_count};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= BOOT;
      pc <= RESET_PC;
      outstanding <= '0;
      drop_cnt <= '0;
    end else begin
      state <= drop_next != '0 ? DRAIN : RUN;
      pc <= redirect_valid ? redirect_pc & ~32'd3 : req_fire ? pc + PC_STEP : pc;
      outstanding <= out_after + CW'(req_fire);
      drop_cnt <= drop_next;
    end
  // PCs of live requests; flushed on redirect so dropped responses never pop it
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_pcq (
    .clk(clk), .reset_n(reset_n), .flush(redirect_valid),
    .push(req_fire), .din('{inst: '0, pc: pc}),
    .pop(keep), .dout(pcq_dout), .count(pcq_count)
  );
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(reset_n), .flush(redirect_valid),
    .push(fifo_push), .din('{inst: imem_rsp_data, pc: pcq_dout.pc}),
    .pop(fifo_pop), .dout(fifo_dout), .count(fifo_count)
  );
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: scoreboard bench for inst_fetch with a 1-cycle memory model.
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 0, reset_n = 0;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic inst_valid, inst_ready = 0;
  logic [31:0] inst, inst_pc;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  int total = 0, bad = 0, nfire = 0;
  logic mem_en = 1, stale_inject = 0;
  logic [31:0] exp_pc = RPC;
  logic [31:0] mq[$];
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  inst_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F17;
  endfunction

  // Memory model and scoreboard: sample at negedge, drive responses 1ns after posedge.
  initial begin
    logic [63:0] e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        sb.delete();
        mq.delete();
        exp_pc = RPC;
      end else begin
        if (inst_valid && inst_ready) begin
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected got inst=%h pc=%h, none expected", inst, inst_pc);
          end else begin
            e = sb.pop_front();
            if ({inst, inst_pc} !== e) begin
              bad++;
              $display("FAIL sb_word got inst=%h pc=%h exp inst=%h pc=%h", inst, inst_pc, e[63:32], e[31:0]);
            end
          end
        end
        if (redirect_valid) begin
          sb.delete();
          exp_pc = redirect_pc & ~32'd3;
        end
        if (imem_req_valid && imem_req_ready) begin
          total++;
          if (imem_req_addr !== exp_pc) begin
            bad++;
            $display("FAIL req_addr got=%h exp=%h", imem_req_addr, exp_pc);
          end
          sb.push_back({word(exp_pc), exp_pc});
          exp_pc += 32'd4;
          mq.push_back(imem_req_addr);
          nfire++;
        end
      end
      @(posedge clk);
      #1;
      if (stale_inject) begin
        stale_inject = 0;
        imem_rsp_valid = 1;
        imem_rsp_data = 32'hDEAD_BEEF;
      end else if (mem_en && mq.size() > 0) begin
        a = mq.pop_front();
        imem_rsp_valid = 1;
        imem_rsp_data = word(a);
      end else begin
        imem_rsp_valid = 0;
        imem_rsp_data = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 0;
    redirect_valid = 0;
    imem_req_ready = 1;
    inst_ready = 1;
    @(negedge clk);
    mem_en = 1;
    @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 30 && !inst_valid; i++) @(negedge clk);
    total++;
    if (!inst_valid) begin
      bad++;
      $display("FAIL %s_timeout got inst_valid=0 exp 1", name);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total += 5;
    if (imem_req_valid !== 0) begin bad++; $display("FAIL rst_req_valid got=%b exp=0", imem_req_valid); end
    if (imem_req_addr !== RPC) begin bad++; $display("FAIL rst_req_addr got=%h exp=%h", imem_req_addr, RPC); end
    if (inst_valid !== 0) begin bad++; $display("FAIL rst_inst_valid got=%b exp=0", inst_valid); end
    if (inst !== 0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst); end
    if (inst_pc !== 0) begin bad++; $display("FAIL rst_inst_pc got=%h exp=0", inst_pc); end
    @(posedge clk);
    #1;
    imem_req_ready = 1;
    inst_ready = 1;
    reset_n = 1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 0) begin bad++; $display("FAIL boot_no_req got=%b exp=0", imem_req_valid); end
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1 || imem_req_addr !== RPC) begin
      bad++;
      $display("FAIL first_req got valid=%b addr=%h exp 1 %h", imem_req_valid, imem_req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    do_reset();
    wait_valid("stream");
    total++;
    if (inst_pc !== RPC) begin bad++; $display("FAIL stream_first_pc got=%h exp=%h", inst_pc, RPC); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      total++;
      if (inst_valid !== 1) begin bad++; $display("FAIL stream_bubble cycle %0d got inst_valid=0 exp 1", i); end
    end
  endtask

  task automatic test_decode_stall();
    int n0;
    do_reset();
    inst_ready = 0;
    n0 = nfire;
    repeat (10) @(negedge clk);
    total += 3;
    if (nfire - n0 !== 2) begin bad++; $display("FAIL stall_reqs got=%0d exp=2", nfire - n0); end
    if (imem_req_valid !== 0) begin bad++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
    if (imem_req_addr !== RPC + 32'h8) begin bad++; $display("FAIL stall_pc got=%h exp=%h", imem_req_addr, RPC + 32'h8); end
    @(posedge clk);
    #1;
    inst_ready = 1;
    @(negedge clk);
    total++;
    if (inst_pc !== RPC) begin bad++; $display("FAIL stall_pop0 got=%h exp=%h", inst_pc, RPC); end
    @(negedge clk);
    total++;
    if (inst_pc !== RPC + 32'h4) begin bad++; $display("FAIL stall_pop1 got=%h exp=%h", inst_pc, RPC + 32'h4); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_redirect();
    int n0;
    do_reset();
    @(negedge clk);
    mem_en = 0;
    n0 = nfire;
    repeat (4) @(negedge clk);
    total++;
    if (nfire - n0 !== 2) begin bad++; $display("FAIL redir_inflight got=%0d exp=2", nfire - n0); end
    @(posedge clk);
    #1;
    redirect_valid = 1;
    redirect_pc = 32'h203;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 0) begin bad++; $display("FAIL redir_req_forced got=%b exp=0", imem_req_valid); end
    mem_en = 1;
    @(posedge clk);
    #1;
    redirect_valid = 0;
    @(negedge clk);
    total += 2;
    if (imem_req_addr !== 32'h200) begin bad++; $display("FAIL redir_addr got=%h exp=200", imem_req_addr); end
    if (inst_valid !== 0) begin bad++; $display("FAIL redir_flush got=%b exp=0", inst_valid); end
    wait_valid("redir");
    total++;
    if (inst_pc !== 32'h200) begin bad++; $display("FAIL redir_first_pc got=%h exp=200", inst_pc); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    redirect_valid = 1;
    redirect_pc = 32'h400;
    @(posedge clk);
    #1;
    redirect_pc = 32'h501;
    @(posedge clk);
    #1;
    redirect_valid = 0;
    @(negedge clk);
    total++;
    if (imem_req_addr !== 32'h500) begin bad++; $display("FAIL b2b_addr got=%h exp=500", imem_req_addr); end
    wait_valid("b2b");
    total++;
    if (inst_pc !== 32'h500) begin bad++; $display("FAIL b2b_first_pc got=%h exp=500", inst_pc); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_req_stall();
    logic [31:0] a;
    do_reset();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1;
    imem_req_ready = 0;
    @(negedge clk);
    a = imem_req_addr;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (imem_req_addr !== a || imem_req_valid !== 1) begin
        bad++;
        $display("FAIL req_hold cycle %0d got valid=%b addr=%h exp 1 %h", i, imem_req_valid, imem_req_addr, a);
      end
    end
    total++;
    if (inst_valid !== 0) begin bad++; $display("FAIL req_hold_drain got inst_valid=%b exp 0", inst_valid); end
    @(posedge clk);
    #1;
    imem_req_ready = 1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_wrap();
    bit found = 0;
    do_reset();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    redirect_valid = 1;
    redirect_pc = 32'hFFFF_FFF8;
    @(posedge clk);
    #1;
    redirect_valid = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = imem_req_valid && imem_req_ready && imem_req_addr == 32'hFFFF_FFFC;
    end
    total++;
    if (!found) begin bad++; $display("FAIL wrap_top got no request at fffffffc, exp one"); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = imem_req_valid && imem_req_ready;
    end
    total++;
    if (!found || imem_req_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got found=%b addr=%h exp 1 00000000", found, imem_req_addr);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst_ready = 0;
    @(negedge clk);
    mem_en = 0;
    repeat (4) @(negedge clk);
    mem_en = 1;
    @(negedge clk);
    mem_en = 0;
    @(posedge clk);
    #2;
    total++;
    if (inst_valid !== 1) begin bad++; $display("FAIL mid_setup got inst_valid=%b exp 1", inst_valid); end
    #1;
    reset_n = 0;
    #1;
    total += 5;
    if (imem_req_valid !== 0) begin bad++; $display("FAIL mid_req_valid got=%b exp=0", imem_req_valid); end
    if (imem_req_addr !== RPC) begin bad++; $display("FAIL mid_req_addr got=%h exp=%h", imem_req_addr, RPC); end
    if (inst_valid !== 0) begin bad++; $display("FAIL mid_inst_valid got=%b exp=0", inst_valid); end
    if (inst !== 0) begin bad++; $display("FAIL mid_inst got=%h exp=0", inst); end
    if (inst_pc !== 0) begin bad++; $display("FAIL mid_inst_pc got=%h exp=0", inst_pc); end
    @(negedge clk);
    mem_en = 1;
    stale_inject = 1;
    inst_ready = 1;
    @(posedge clk);
    #1;
    reset_n = 1;
    wait_valid("mid");
    total++;
    if (inst_pc !== RPC || inst !== word(RPC)) begin
      bad++;
      $display("FAIL mid_restart got inst=%h pc=%h exp %h %h", inst, inst_pc, word(RPC), RPC);
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_decode_stall();
    test_redirect();
    test_back_to_back();
    test_req_stall();
    test_wrap();
    test_reset_mid();
    @(posedge clk);
    #1;
    imem_req_ready = 0;
    inst_ready = 1;
    repeat (8) @(negedge clk);
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL drain_left got=%0d words exp=0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
